ysyx_25040105_exu_seq: RTL

//  Sequential execute unit; successor to the combinational EXU. Full RV32I ALU op set plus

---
 rtl/ysyx_25040105_exu_pkg.sv | 51 +++++
 rtl/ysyx_25040105_muldiv_iter.sv | 122 ++++++++++++
 rtl/ysyx_25040105_exu_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/ysyx_25040105_exu_pkg.sv
// Shared definitions for the sequential execute unit:
// op codes, op-class helpers and FSM state encoding.
package ysyx_25040105_exu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
    localparam logic [OP_W-1:0] OP_SLL    = 5'd2;
    localparam logic [OP_W-1:0] OP_SRL    = 5'd3;
    localparam logic [OP_W-1:0] OP_SRA    = 5'd4;
    localparam logic [OP_W-1:0] OP_SLT    = 5'd5;
    localparam logic [OP_W-1:0] OP_SLTU   = 5'd6;
    localparam logic [OP_W-1:0] OP_XOR    = 5'd7;
    localparam logic [OP_W-1:0] OP_OR     = 5'd8;
    localparam logic [OP_W-1:0] OP_AND    = 5'd9;
    localparam logic [OP_W-1:0] OP_PASSB  = 5'd10;
    localparam logic [OP_W-1:0] OP_MUL    = 5'd16;
    localparam logic [OP_W-1:0] OP_MULH   = 5'd17;
    localparam logic [OP_W-1:0] OP_MULHSU = 5'd18;
    localparam logic [OP_W-1:0] OP_MULHU  = 5'd19;
    localparam logic [OP_W-1:0] OP_DIV    = 5'd20;
    localparam logic [OP_W-1:0] OP_DIVU   = 5'd21;
    localparam logic [OP_W-1:0] OP_REM    = 5'd22;
    localparam logic [OP_W-1:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Operand A is treated as signed
    function automatic logic is_signed(input logic [OP_W-1:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // Operand B is treated as signed (MULHSU keeps B unsigned)
    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ysyx_25040105_muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide
// on magnitudes, one bit per cycle, sign fixed up at the end.
module ysyx_25040105_muldiv_iter
    import ysyx_25040105_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = SHAMT_W + 1;

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_q;
    logic [XLEN-1:0]   a_q;
    logic              neg_q, rneg_q, dz_q, ovf_q;
    logic [2*XLEN-1:0] acc, mc;
    logic [XLEN-1:0]   mp, rem, dv;

    logic              sa, sb;
    logic [XLEN-1:0]   ma, mb;
    logic [XLEN:0]     trial, diff;
    logic [2*XLEN-1:0] acc_n, mc_n, prod;
    logic [XLEN-1:0]   mp_n, rem_n, quo, rmd;

    assign sa = is_signed(op) & a[XLEN-1];
    assign sb = is_signed_b(op) & b[XLEN-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    assign trial = {rem, mp[XLEN-1]};
    assign diff  = trial - {1'b0, dv};

    // Last iteration is folded into the result so DONE lands on the final step
    assign done = busy && (cnt == CNT_W'(XLEN - 1));

    // One multiply or divide step computed from the current state
    always_comb begin
        acc_n = acc;
        mc_n  = mc << 1;
        mp_n  = mp;
        rem_n = rem;
        if (is_mul(op_q)) begin
            if (mp[0]) acc_n = acc + mc;
            mp_n = mp >> 1;
        end else if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            mp_n  = {mp[XLEN-2:0], 1'b1};
        end else begin
            rem_n = trial[XLEN-1:0];
            mp_n  = {mp[XLEN-2:0], 1'b0};
        end
    end

    assign prod = neg_q  ? -acc_n : acc_n;
    assign quo  = neg_q  ? -mp_n  : mp_n;
    assign rmd  = rneg_q ? -rem_n : rem_n;

    // Result select with divide-by-zero and signed-overflow fixups
    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = dz_q ? '1 : (ovf_q ? a_q : quo);
            OP_REM, OP_REMU:              result = dz_q ? a_q : (ovf_q ? '0 : rmd);
            default:                      result = '0;
        endcase
    end

    // Operand load on start, then one step per cycle until the count expires
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            busy   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            rem    <= '0;
            dv     <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            op_q   <= op;
            a_q    <= a;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            dz_q   <= (b == '0);
            ovf_q  <= (op == OP_DIV || op == OP_REM)
                      && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
            acc    <= '0;
            mc     <= {{XLEN{1'b0}}, ma};
            mp     <= is_mul(op) ? mb : ma;
            rem    <= '0;
            dv     <= mb;
        end else if (busy) begin
            acc <= acc_n;
            mc  <= mc_n;
            mp  <= mp_n;
            rem <= rem_n;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_25040105_exu_seq.sv
// Sequential execute unit: single-cycle ALU plus iterative
// RV32M, one op in flight behind valid/ready handshakes.
module ysyx_25040105_exu_seq
    import ysyx_25040105_exu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [OP_W-1:0] alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result
);

    localparam int SHAMT_W = $clog2(XLEN);

    state_t             state;
    logic [XLEN-1:0]    op_b, alu_res, md_result;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, take_m, md_done;

    assign op_b     = alu_src ? imm : rs2_data;
    assign shamt    = op_b[SHAMT_W-1:0];
    assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign take_m   = M_EXT && (is_mul(alu_op) || is_div(alu_op));

    // Single-cycle ALU; M ops without M_EXT and undefined codes give 0
    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            OP_ADD:   alu_res = rs1_data + op_b;
            OP_SUB:   alu_res = rs1_data - op_b;
            OP_SLL:   alu_res = rs1_data << shamt;
            OP_SRL:   alu_res = rs1_data >> shamt;
            OP_SRA:   alu_res = $signed(rs1_data) >>> shamt;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}},
                                 $signed(rs1_data) < $signed(op_b)};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs1_data < op_b};
            OP_XOR:   alu_res = rs1_data ^ op_b;
            OP_OR:    alu_res = rs1_data | op_b;
            OP_AND:   alu_res = rs1_data & op_b;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    ysyx_25040105_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (accept && take_m),
        .op     (alu_op),
        .a      (rs1_data),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    // Handshake FSM with registered result and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            alu_result <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept && take_m) begin
                        state     <= ST_BUSY;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        alu_result <= alu_res;
                    end else if (state == ST_DONE && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        alu_result <= md_result;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
